// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Binary-to-BCD converter feeding a multiplexed active-low 7-seg scan
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int DIGITS  = 4,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic              signed_mode,
  input  logic              blank_lz,
  output logic              busy,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int c_NIB   = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int c_BCD_W = 4 * c_NIB;
  localparam int c_EXT   = (c_NIB > DIGITS) ? c_NIB : DIGITS;
  localparam int c_CNT_W = $clog2(DATA_W + 1);
  localparam int c_DIV_W = $clog2(CLK_DIV);
  localparam int c_IDX_W = $clog2(DIGITS);
  localparam logic [7:0] c_BLANK = 8'hff;
  localparam logic [7:0] c_MINUS = 8'hbf;
  localparam logic [7:0] c_ZERO  = 8'hc0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t               r_state, w_next;
  logic [c_BCD_W-1:0]   r_bcd, w_bcd_adj;
  logic [DATA_W-1:0]    r_bin;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_neg, r_blank;
  logic [7:0]           r_disp [DIGITS];
  logic [7:0]           w_code [DIGITS];
  logic [4*c_EXT-1:0]   w_ext;
  logic                 w_ovf;
  int                   w_msd;
  logic [c_DIV_W-1:0]   r_div;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nx;

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0: return 8'hc0;
      4'd1: return 8'hf9;
      4'd2: return 8'ha4;
      4'd3: return 8'hb0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hf8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hff;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (load) w_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == c_CNT_W'(DATA_W - 1)) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < c_NIB; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // A negative result needs one digit reserved for the minus sign.
  always_comb begin
    w_ext = '0;
    w_ext[c_BCD_W-1:0] = r_bcd;
    w_ovf = 1'b0;
    w_msd = 0;
    for (int i = 0; i < c_EXT; i++) begin
      if (w_ext[4*i +: 4] != 4'd0) begin
        if (i >= (r_neg ? DIGITS - 1 : DIGITS)) w_ovf = 1'b1;
        if (i < DIGITS) w_msd = i;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (w_ovf)
        w_code[i] = c_MINUS;
      else if (r_blank && i > w_msd)
        w_code[i] = (r_neg && i == w_msd + 1) ? c_MINUS : c_BLANK;
      else if (!r_blank && r_neg && i == DIGITS - 1)
        w_code[i] = c_MINUS;
      else
        w_code[i] = f_seg(w_ext[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_blank <= 1'b1;
      for (int i = 0; i < DIGITS; i++) r_disp[i] <= (i == 0) ? c_ZERO : c_BLANK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin   <= (signed_mode && value[DATA_W-1]) ? -value : value;
            r_neg   <= signed_mode && value[DATA_W-1];
            r_blank <= blank_lz;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
        end
        S_COMMIT: begin
          for (int i = 0; i < DIGITS; i++) r_disp[i] <= w_code[i];
        end
        default: ;
      endcase
    end
  end

  assign w_idx_nx = (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

  // seg and an load together at the slot boundary so digits never bleed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_idx <= c_IDX_W'(DIGITS - 1);
      seg   <= c_BLANK;
      an    <= '1;
    end else if (r_div == c_DIV_W'(CLK_DIV - 1)) begin
      r_div <= '0;
      r_idx <= w_idx_nx;
      seg   <= r_disp[w_idx_nx];
      an    <= ~({{(DIGITS-1){1'b0}}, 1'b1} << w_idx_nx);
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Self-checking bench for seg_scan_driver (DIGITS=4, DATA_W=16, CLK_DIV=4)
// Revision : 1.1 - self-checking scenarios and failure reporting
// ============================================================================
module tb_seg_scan_driver;
    localparam int c_DIGITS  = 4;
    localparam int c_DATA_W  = 16;
    localparam int c_CLK_DIV = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [c_DATA_W-1:0] value = '0;
    logic                load = 1'b0;
    logic                signed_mode = 1'b0;
    logic                blank_lz = 1'b0;
    logic                busy;
    logic [7:0]          seg;
    logic [c_DIGITS-1:0] an;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.DIGITS(c_DIGITS), .DATA_W(c_DATA_W), .CLK_DIV(c_CLK_DIV)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .signed_mode(signed_mode),
        .blank_lz(blank_lz), .busy(busy), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dig_code(input int d);
        case (d)
            0: return 8'hc0;
            1: return 8'hf9;
            2: return 8'ha4;
            3: return 8'hb0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hf8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hff;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [15:0] v, input bit sm, input bit bl);
        int mag, nd, d;
        bit neg;
        logic [31:0] r;
        neg = sm && v[15];
        mag = neg ? 65536 - int'(v) : int'(v);
        if ((neg && mag > 999) || (!neg && mag > 9999)) return {4{8'hbf}};
        nd = 1;
        for (int t = mag / 10; t > 0; t = t / 10) nd++;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            d = (mag / (10 ** i)) % 10;
            if (bl && i >= nd)             r[8*i +: 8] = (neg && i == nd) ? 8'hbf : 8'hff;
            else if (!bl && neg && i == 3) r[8*i +: 8] = 8'hbf;
            else                           r[8*i +: 8] = dig_code(d);
        end
        return r;
    endfunction

    task automatic chk(input bit ok, input string name);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s at %0t", name, $time);
        end
    endtask

    task automatic chk32(input logic [31:0] got, input logic [31:0] exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $error("FAIL %s: got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_idle(output int bcyc);
        bcyc = 0;
        for (int k = 0; k < 60 && busy; k++) begin
            bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input bit sm, input bit bl, output int bcyc);
        @(negedge clk);
        value = v; signed_mode = sm; blank_lz = bl; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(bcyc);
    endtask

    task automatic collect(output logic [31:0] obs, output logic [3:0] seen, output bit bad_an);
        obs = '1; seen = '0; bad_an = 1'b0;
        repeat (c_CLK_DIV + 1) @(negedge clk);
        repeat (c_CLK_DIV * c_DIGITS) begin
            case (an)
                4'b1110: begin obs[7:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin obs[15:8]  = seg; seen[1] = 1'b1; end
                4'b1011: begin obs[23:16] = seg; seen[2] = 1'b1; end
                4'b0111: begin obs[31:24] = seg; seen[3] = 1'b1; end
                default: bad_an = 1'b1;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic load_and_check(input logic [15:0] v, input bit sm, input bit bl, input string name);
        int bc;
        logic [31:0] obs;
        logic [3:0] seen;
        bit bad;
        do_load(v, sm, bl, bc);
        chk(bc == 17, {name, " busy length"});
        collect(obs, seen, bad);
        chk(seen == 4'hf && !bad, {name, " scan"});
        chk32(obs, model(v, sm, bl), {name, " display"});
    endtask

    initial begin
        int bc;
        logic [31:0] obs;
        logic [3:0] seen;
        bit bad;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk({busy, seg, an} === {1'b0, 8'hff, 4'hf}, "reset values");
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({seg, an} === {8'hff, 4'hf}, "post-reset idle scan");
        end
        @(negedge clk);
        chk({seg, an} === {8'hc0, 4'he}, "first slot digit0");
        repeat (c_CLK_DIV) @(negedge clk);
        chk({seg, an} === {8'hff, 4'hd}, "second slot digit1");

        load_and_check(16'd1234, 1'b0, 1'b0, "1234");
        load_and_check(16'd7, 1'b0, 1'b1, "7 blank");
        load_and_check(16'd0, 1'b0, 1'b0, "0 noblank");
        load_and_check(16'hFF85, 1'b1, 1'b1, "-123");
        load_and_check(16'h8000, 1'b1, 1'b0, "0x8000 overflow");
        load_and_check(16'd12345, 1'b0, 1'b0, "12345 overflow");
        load_and_check(16'd9999, 1'b0, 1'b0, "9999");
        load_and_check(16'hFC19, 1'b1, 1'b0, "-999");

        @(negedge clk);
        value = 16'd5678; signed_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        value = 16'd1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk(busy === 1'b1, "busy during ignored load");
        wait_idle(bc);
        chk(bc == 14, "busy not restarted by ignored load");
        collect(obs, seen, bad);
        chk32(obs, model(16'd5678, 1'b0, 1'b0), "5678 kept");

        @(negedge clk);
        value = 16'd4321; signed_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk({busy, seg, an} === {1'b0, 8'hff, 4'hf}, "async reset mid-conversion");
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk(busy === 1'b0, "idle after reset abort");
        collect(obs, seen, bad);
        chk(seen == 4'hf && !bad, "scan after reset abort");
        chk32(obs, {8'hff, 8'hff, 8'hff, 8'hc0}, "display reverted to 0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors == 0) $display("TEST PASSED");
        else             $display("TEST FAILED");
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment display driver for the calculator front panel. It accepts a binary operand or result on a load strobe and converts it to BCD with a sequential shift-add-3 engine. It then time-multiplexes the digits onto a common active-low segment bus, with optional leading-zero blanking, a signed minus sign and overflow indication. It sits between the calculator datapath and the board's segment/anode pins.

## Interface
- DIGITS, 4, number of physical digits, 2..8
- DATA_W, 16, width of `value`, 4..32
- CLK_DIV, 50000, clk cycles per digit scan slot, >=2
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- value  input  DATA_W  operand; unsigned, or two's complement when `signed_mode`=1
- load  input  1  one-cycle strobe; captures `value`, `signed_mode`, `blank_lz`
- signed_mode  input  1  interpret `value` as two's complement
- blank_lz  input  1  blank leading zeros
- busy  output  1  conversion in progress
- seg  output  8  segment code, active-low, bit7 = dp (always 1/off)
- an  output  DIGITS  digit enable, active-low one-hot; an[0] = least significant digit

## Operation
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-low.
- Segment codes: 0 c0, 1 f9, 2 a4, 3 b0, 4 99, 5 92, 6 82, 7 f8, 8 80, 9 90, blank ff, minus bf.
- Conversion FSM states:
  - IDLE: `load`=1 captures the magnitude and goes to SHIFT. The magnitude is `value`, or its two's-complement negation when `signed_mode`=1 and the MSB=1; that case also sets neg. `signed_mode` and `blank_lz` are latched at the same edge.
  - SHIFT: DATA_W iterations. Each one adds 3 to every BCD nibble >=5, then shifts the {bcd, bin} register left by 1. The BCD register holds ceil(DATA_W*0.302)+1 nibbles.
  - COMMIT: 1 cycle. Builds the DIGITS display codes, writes the display registers atomically, then returns to IDLE.
- Capacity: an unsigned value fits if the magnitude is <= 10^DIGITS-1. A negative value fits if the magnitude is <= 10^(DIGITS-1)-1.
- Overflow (value does not fit): all digits show minus (bf).
- Digit codes at COMMIT:
  - blank_lz=0: every digit shows its decimal digit. A negative value shows minus in digit DIGITS-1.
  - blank_lz=1: digits above the most significant nonzero digit are blank. Digit 0 always shows, so 0 displays as "0". A negative value places minus in the digit immediately above the most significant shown digit.
- The most negative input (-2^(DATA_W-1)) negates to its correct unsigned magnitude.
- Scan: a divider counts 0..CLK_DIV-1. At terminal count the digit index advances 0→DIGITS-1 and wraps to 0. `seg` and `an` are registered from the display registers for that index.
- Because the display registers change only in COMMIT, the scan never shows a partially converted value.

## Timing
- Reset values:
  - busy=0, state IDLE, `seg`=ff, `an`=all ones (all off)
  - divider=0, digit index=DIGITS-1, so the first slot after reset is digit 0
  - display registers hold value 0 with blank_lz=1 (digit0 c0, others ff)
- `load` is sampled only in IDLE. A `load` while busy=1 is ignored, with no queueing.
- `busy` rises the edge after `load` is sampled. It stays high for exactly DATA_W+1 cycles (SHIFT + COMMIT).
- Display registers update at the edge that ends COMMIT. The new value appears on `seg` at the next scan slot boundary.
- A `load` in the same cycle busy falls is not accepted. A `load` one cycle later is accepted.
- The first `an`/`seg` update is CLK_DIV cycles after reset release. After that, each digit is driven for exactly CLK_DIV cycles.
- `seg` and `an` change on the same edge, so no cross-digit glitch is possible.
- Reset mid-conversion aborts: all state returns to reset values immediately, and no partial result is ever committed.
- The scan continues uninterrupted during conversion.

## Test plan
All scenarios use DIGITS=4, DATA_W=16, CLK_DIV=4.
- Reset, then release → seg=ff and an=f for 4 cycles; then an=e, seg=c0; then an=d, seg=ff.
- load 1234, unsigned, blank_lz=0 → busy high exactly 17 cycles. Scan then shows an=e:99, d:b0, b:a4, 7:f9.
- load 7, blank_lz=1 → digit0 f8, digits1–3 ff. Then load 0, blank_lz=0 → c0 on all four digits.
- load 0xFF85 (-123), signed, blank_lz=1 → digit0 b0, digit1 a4, digit2 f9, digit3 bf. Then load 0x8000, signed → all bf (overflow).
- load 12345, unsigned → all bf. Then load 9999 → 90 on all digits. Then load 0xFC19 (-999), signed, blank_lz=0 → 90, 90, 90, bf.
- load 5678, then a second load 1111 3 cycles later → second load ignored, display 5678. Then load 4321 with rst pulsed low at SHIFT cycle 8 → display reverts to "0" with busy=0, and 4321 never appears.
